// File: rtl/easy_axi_slv.sv
// easy_axi_slv: AXI read-side responder.
//
// Accepts AR requests into an in-order outstanding FIFO and answers each one
// with a single-beat R response after a programmable wait. The R data is a
// deterministic pattern, zero-extended {arid, araddr}, so that benches driving
// this slave can predict every response.
//
// Optional feature macro: EASYAXI_SLV_DECERR_EN
//   When defined, requests with araddr >= ADDR_LIMIT are answered with
//   rresp=2'b11 (DECERR) and rdata=0. They keep the same latency and ordering.
//
// Parameters:
//   OST_DEPTH   outstanding FIFO depth (power of two, >= 2)
//   RD_LATENCY  wait cycles before the head request is answered (>= 1)
//   ADDR_LIMIT  first address outside the decoded region (DECERR build only)
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   axi_slv_arvalid  AR valid (in)
//   axi_slv_arready  AR ready (out), high while the FIFO is not full
//   axi_slv_arid     AR ID (in)
//   axi_slv_araddr   AR address (in)
//   axi_slv_rvalid   R valid (out)
//   axi_slv_rready   R ready (in)
//   axi_slv_rid      R ID (out), echoes the answered arid
//   axi_slv_rdata    R data (out)
//   axi_slv_rresp    R response (out), OKAY or DECERR
//   axi_slv_rlast    R last (out), high with every beat

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module easy_axi_slv #(
  parameter int                          OST_DEPTH  = 4,
  parameter int                          RD_LATENCY = 2,
  parameter logic [`AXI_ADDR_WIDTH-1:0]  ADDR_LIMIT = 16'h0100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        axi_slv_arvalid,
  output logic                        axi_slv_arready,
  input  logic [`AXI_ID_WIDTH-1:0]    axi_slv_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0]  axi_slv_araddr,
  output logic                        axi_slv_rvalid,
  input  logic                        axi_slv_rready,
  output logic [`AXI_ID_WIDTH-1:0]    axi_slv_rid,
  output logic [`AXI_DATA_WIDTH-1:0]  axi_slv_rdata,
  output logic [1:0]                  axi_slv_rresp,
  output logic                        axi_slv_rlast
);

  localparam int IW = `AXI_ID_WIDTH;
  localparam int AW = `AXI_ADDR_WIDTH;
  localparam int DW = `AXI_DATA_WIDTH;
  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [CW-1:0] FULL     = CW'(OST_DEPTH);
  localparam logic [LW-1:0] LAST_CNT = LW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [LW-1:0]   cnt;
  logic [LW-1:0]   next_cnt;
  logic            load_resp;

  logic [IW-1:0]   fifo_id   [OST_DEPTH];
  logic [AW-1:0]   fifo_addr [OST_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic            push;
  logic            pop;
  logic [IW-1:0]   head_id;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   resp_data;
  logic [1:0]      resp_code;

  logic [IW-1:0]   rid_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      rresp_q;

  // Ready comes only from the registered count, so a pop in the same cycle
  // never opens a slot early when the FIFO is full.
  assign axi_slv_arready = (count != FULL);
  assign push            = axi_slv_arvalid & axi_slv_arready;
  assign pop             = (state == S_RESP) & axi_slv_rready;
  assign count_next      = count + CW'(push) - CW'(pop);

  assign head_id   = fifo_id[rd_ptr];
  assign head_addr = fifo_addr[rd_ptr];

`ifdef EASYAXI_SLV_DECERR_EN
  // Out-of-range requests are still answered in order, just with DECERR.
  always_comb begin
    resp_data = DW'({head_id, head_addr});
    resp_code = 2'b00;
    if (head_addr >= ADDR_LIMIT) begin
      resp_data = '0;
      resp_code = 2'b11;
    end
  end
`else
  always_comb begin
    resp_data = DW'({head_id, head_addr});
    resp_code = 2'b00;
  end
`endif

  // FIFO storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]   <= axi_slv_arid;
      fifo_addr[wr_ptr] <= axi_slv_araddr;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Leaving RESP looks at the post-pop count including a same-edge push, so
  // a request arriving exactly at the handshake is not parked in IDLE.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    load_resp  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          next_state = S_WAIT;
          next_cnt   = '0;
        end
      end
      S_WAIT: begin
        if (cnt == LAST_CNT) begin
          next_state = S_RESP;
          load_resp  = 1'b1;
        end else begin
          next_cnt = cnt + LW'(1);
        end
      end
      S_RESP: begin
        if (axi_slv_rready) begin
          next_cnt   = '0;
          next_state = (count_next != '0) ? S_WAIT : S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // The payload is captured once on entry to RESP and held until the next
  // load, which keeps it stable while the master stalls rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rid_q   <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else if (load_resp) begin
      rid_q   <= head_id;
      rdata_q <= resp_data;
      rresp_q <= resp_code;
    end
  end

  assign axi_slv_rvalid = (state == S_RESP);
  assign axi_slv_rlast  = (state == S_RESP);
  assign axi_slv_rid    = rid_q;
  assign axi_slv_rdata  = rdata_q;
  assign axi_slv_rresp  = rresp_q;

endmodule

// File: doc/easy_axi_slv.md
Name: easy_axi_slv

Overview:
- AXI read-side responder: accepts AR requests from the master and returns one single-beat R response per request.
- Accepted requests queue in an outstanding FIFO and are answered in order after a programmable latency.
- R data is a deterministic pattern built from the request, so a bench can self-check.
- Serves as the slave endpoint for the existing master in loopback and integration benches.

Parameters:
- OST_DEPTH, 4: outstanding request FIFO depth; power of two, >=2.
- RD_LATENCY, 2: wait cycles before a head request is answered; >=1.
- ADDR_LIMIT, 16'h0100: first address outside the decoded region; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- axi_slv_arvalid  in  1  AR valid.
- axi_slv_arready  out  1  AR ready.
- axi_slv_arid  in  `AXI_ID_WIDTH  AR ID.
- axi_slv_araddr  in  `AXI_ADDR_WIDTH  AR address.
- axi_slv_rvalid  out  1  R valid.
- axi_slv_rready  in  1  R ready.
- axi_slv_rid  out  `AXI_ID_WIDTH  R ID; equals the ID of the answered AR.
- axi_slv_rdata  out  `AXI_DATA_WIDTH  R data.
- axi_slv_rresp  out  2  R response; 2'b00 OKAY, 2'b11 DECERR.
- axi_slv_rlast  out  1  R last; always 1 while rvalid=1 (single beat).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - arready=1 (FIFO empty); rvalid=0; rid=0; rdata=0; rresp=0; rlast=0.
  - FIFO count, pointers, latency counter and FSM (IDLE) all cleared.
- Reset mid-operation: all outstanding requests are discarded and rvalid drops at that edge. No response is produced for discarded requests.
- AR channel:
  - arready = (count != OST_DEPTH), decoded combinationally from the registered count.
  - Handshake when arvalid & arready: push {arid, araddr}; count increments unless a pop happens at the same edge.
  - No full bypass: when full, arready stays 0 even if an R pop occurs in the same cycle.
- FSM states IDLE, WAIT, RESP:
  - IDLE: count==0. Goes to WAIT at the first edge where the FIFO is non-empty, with cnt=0.
  - WAIT: cnt increments each edge. When cnt==RD_LATENCY-1, go to RESP and register the R payload from the FIFO head.
  - RESP: rvalid=1; rid/rdata/rresp/rlast stay stable until rready.
  - RESP on rvalid & rready: pop the head. Go to WAIT (cnt=0) if entries remain after the pop, counting any push at the same edge; otherwise go to IDLE and drop rvalid.
- Latency:
  - From idle, rvalid rises RD_LATENCY+1 edges after the AR handshake edge.
  - Back-to-back, rvalid rises RD_LATENCY edges after the previous R handshake edge.
- Ordering: strictly in order; rid sequence equals the accepted arid sequence.
- Data pattern: rdata = zero-extended {arid, araddr}, with araddr in bits [`AXI_ADDR_WIDTH-1:0] and arid directly above it. Requires `AXI_DATA_WIDTH >= `AXI_ADDR_WIDTH + `AXI_ID_WIDTH.
- rresp=2'b00 always, unless the optional feature is enabled.
- Simultaneous push and pop: count unchanged; pointers wrap modulo OST_DEPTH.
- rready held low: the slave keeps rvalid and the payload, and keeps accepting AR until full.

Optional Feature:
- Macro: EASYAXI_SLV_DECERR_EN.
- Defined: a request with araddr >= ADDR_LIMIT is answered with rresp=2'b11 and rdata=0, with the same latency and ordering as a normal request. rid is still echoed.
- Not defined: the ADDR_LIMIT comparison is absent; every response is rresp=2'b00 with the pattern data.

Test Plan:
- Reset then a single AR (id=4'h3, addr=16'h0040), RD_LATENCY=2, rready=1 -> rvalid rises 3 edges after the AR handshake edge; rid=3, rdata=32'h0003_0040, rresp=0, rlast=1; rvalid drops after 1 cycle.
- 5 ARs with ids 0..4, rready=0, OST_DEPTH=4 -> arready=0 after the 4th acceptance and the 5th waits. Release rready: responses in order with ids 0..3; the 5th is accepted the edge after the first pop, and its response has rid=4.
- Continuous arvalid and rready=1 with ids 0..9 -> 10 responses in order; back-to-back rvalid spacing is RD_LATENCY edges; count never exceeds OST_DEPTH.
- rready toggled randomly during RESP -> rid/rdata/rresp stay stable while rvalid=1 and rready=0; no response is lost or duplicated.
- rst asserted for 1 cycle with 3 requests outstanding -> rvalid=0 and arready=1 next cycle; no stale response appears afterwards.
- EASYAXI_SLV_DECERR_EN defined, addr=16'h0100 then 16'h00FF -> rresp=2'b11 with rdata=0, then rresp=2'b00 with rdata=32'h0000_00FF (id 0).
